// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared state encoding and line constants for the USB transmit serializer
// Contents: tx_state_t FSM states, SYNC_BYTE pattern, STUFF_LIMIT ones-run length, EOP_BITS length.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [2:0] STUFF_LIMIT = 3'd6;
    localparam int         EOP_BITS    = 2;

endpackage

// File: rtl/usb_tx_bit_timer.sv
// rtl/usb_tx_bit_timer.sv - bit-period timer producing the per-bit strobe
// Ports: clk, n_rst (async active-low); enable holds the counter at 0 when low;
//        strobe is high in the last cycle of every enabled bit period.
module usb_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    output logic strobe
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign strobe = enable && (cnt == LAST);

endmodule

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - byte-to-bit serializer with bit stuffing and EOP ahead of the NRZI encoder
// Ports: clk, n_rst (async active-low); tx_byte/tx_valid/tx_last/tx_ready byte handshake into a
//        one-byte hold register; data_out/eop/new_bit feed the encoder; tx_busy spans a packet;
//        underrun pulses when the hold register is empty at a byte boundary mid-packet.
// Build option: define USB_TX_SYNC_GEN_EN to prefix every packet with the SYNC byte.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       data_out,
    output logic       eop,
    output logic       new_bit,
    output logic       tx_busy,
    output logic       underrun
);

    tx_state_t   state_q, state_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_last_q, hold_last_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  shift_q, shift_d;
    logic        shift_last_q, shift_last_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [2:0]  ones_q, ones_d;
    logic        eop_cnt_q, eop_cnt_d;
    // A stuff bit interrupts SYNC or DATA; these remember what to resume and
    // whether the interrupted byte had already issued its 8th bit.
    logic        resume_sync_q, resume_sync_d;
    logic        byte_end_q, byte_end_d;
    logic        underrun_q, underrun_d;
    logic        end_byte;

    usb_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .enable (state_q != IDLE),
        .strobe (new_bit)
    );

    assign tx_ready = !hold_full_q;
    assign tx_busy  = (state_q != IDLE);
    assign eop      = (state_q == EOP);
    assign underrun = underrun_q;

    always_comb begin
        data_out = 1'b1;
        case (state_q)
            SYNC:    data_out = SYNC_BYTE[bit_idx_q];
            DATA:    data_out = shift_q[bit_idx_q];
            STUFF:   data_out = 1'b0;
            default: data_out = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        hold_data_d   = hold_data_q;
        hold_last_d   = hold_last_q;
        hold_full_d   = hold_full_q;
        shift_d       = shift_q;
        shift_last_d  = shift_last_q;
        bit_idx_d     = bit_idx_q;
        ones_d        = ones_q;
        eop_cnt_d     = eop_cnt_q;
        resume_sync_d = resume_sync_q;
        byte_end_d    = byte_end_q;
        underrun_d    = 1'b0;
        end_byte      = 1'b0;

        if (tx_valid && !hold_full_q) begin
            hold_data_d = tx_byte;
            hold_last_d = tx_last;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                ones_d    = 3'd0;
                bit_idx_d = 3'd0;
                eop_cnt_d = 1'b0;
                if (hold_full_q) begin
                    shift_d      = hold_data_q;
                    shift_last_d = hold_last_q;
                    hold_full_d  = 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
                    state_d      = SYNC;
`else
                    state_d      = DATA;
`endif
                end
            end
            SYNC, DATA: begin
                if (new_bit) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    ones_d    = data_out ? ones_q + 3'd1 : 3'd0;
                    if (data_out && ones_d == STUFF_LIMIT) begin
                        state_d       = STUFF;
                        resume_sync_d = (state_q == SYNC);
                        byte_end_d    = (bit_idx_q == 3'd7);
                    end else if (bit_idx_q == 3'd7) begin
                        end_byte = 1'b1;
                    end
                end
            end
            STUFF: begin
                if (new_bit) begin
                    ones_d = 3'd0;
                    if (byte_end_q) begin
                        end_byte = 1'b1;
                    end else begin
                        state_d = resume_sync_q ? SYNC : DATA;
                    end
                end
            end
            EOP: begin
                if (new_bit) begin
                    if (eop_cnt_q == 1'(EOP_BITS - 1)) begin
                        state_d   = IDLE;
                        eop_cnt_d = 1'b0;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Byte boundary: after SYNC the already-loaded first data byte follows;
        // after a data byte either finish, chain the held byte, or abort.
        if (end_byte) begin
            if (state_q == SYNC || (state_q == STUFF && resume_sync_q)) begin
                state_d = DATA;
            end else if (shift_last_q) begin
                state_d = EOP;
            end else if (hold_full_q) begin
                shift_d      = hold_data_q;
                shift_last_d = hold_last_q;
                hold_full_d  = 1'b0;
                state_d      = DATA;
            end else begin
                underrun_d = 1'b1;
                state_d    = EOP;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            hold_data_q   <= 8'h00;
            hold_last_q   <= 1'b0;
            hold_full_q   <= 1'b0;
            shift_q       <= 8'h00;
            shift_last_q  <= 1'b0;
            bit_idx_q     <= 3'd0;
            ones_q        <= 3'd0;
            eop_cnt_q     <= 1'b0;
            resume_sync_q <= 1'b0;
            byte_end_q    <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_data_q   <= hold_data_d;
            hold_last_q   <= hold_last_d;
            hold_full_q   <= hold_full_d;
            shift_q       <= shift_d;
            shift_last_q  <= shift_last_d;
            bit_idx_q     <= bit_idx_d;
            ones_q        <= ones_d;
            eop_cnt_q     <= eop_cnt_d;
            resume_sync_q <= resume_sync_d;
            byte_end_q    <= byte_end_d;
            underrun_q    <= underrun_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb/tb_usb_tx_serializer.sv - self-checking bench for usb_tx_serializer
module tb_usb_tx_serializer;

    localparam int CPB = 8;
`ifdef USB_TX_SYNC_GEN_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, data_out, eop, new_bit, tx_busy, underrun;

    always #5 clk = ~clk;

    usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .data_out (data_out),
        .eop      (eop),
        .new_bit  (new_bit),
        .tx_busy  (tx_busy),
        .underrun (underrun)
    );

    int checks = 0;
    int failures = 0;

    // Line monitor: every event is appended, never cleared; tests remember start indices.
    int         cyc = 0;
    logic [1:0] cap_q[$];
    int         nb_cyc_q[$];
    int         rdy_at_q[$];
    int         rdy_after_q[$];
    int         und_q[$];
    int         rise_q[$];
    int         fall_q[$];
    logic       prev_busy = 1'b0;
    logic       prev_nb = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (prev_nb) rdy_after_q.push_back(int'(tx_ready));
        if (new_bit) begin
            cap_q.push_back({eop, data_out});
            nb_cyc_q.push_back(cyc);
            rdy_at_q.push_back(int'(tx_ready));
        end
        if (underrun) und_q.push_back(cap_q.size());
        if (tx_busy && !prev_busy) rise_q.push_back(cyc);
        if (!tx_busy && prev_busy) fall_q.push_back(cyc);
        prev_busy <= tx_busy;
        prev_nb   <= new_bit;
    end

    logic [7:0] pkt[$];
    logic [1:0] exp_q[$];

    // Reference: the packet as a flat LSB-first bit list, a zero inserted after
    // every sixth consecutive one, then two EOP periods.
    function automatic void build_expected();
        logic bits[$];
        int   run;
        exp_q.delete();
        if (SYNC_EN) for (int i = 0; i < 8; i++) bits.push_back(i == 7);
        foreach (pkt[k]) for (int i = 0; i < 8; i++) bits.push_back(pkt[k][i]);
        run = 0;
        foreach (bits[j]) begin
            exp_q.push_back({1'b0, bits[j]});
            run = bits[j] ? run + 1 : 0;
            if (run == 6) begin
                exp_q.push_back(2'b00);
                run = 0;
            end
        end
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b11);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic feed(input bit mark_last, input string tag);
        int g;
        for (int i = 0; i < pkt.size(); i++) begin
            tx_byte  = pkt[i];
            tx_last  = mark_last && (i == pkt.size() - 1);
            tx_valid = 1'b1;
            g = 0;
            while (!tx_ready && g < 5000) begin
                @(negedge clk);
                g++;
            end
            check($sformatf("%s_feed_ready%0d", tag, i), int'(tx_ready), 1);
            @(negedge clk);
            tx_valid = 1'b0;
            tx_last  = 1'b0;
        end
    endtask

    task automatic run_packet(input bit mark_last, input string tag);
        int start, rstart, fstart, ustart, g, n;
        start  = cap_q.size();
        rstart = rise_q.size();
        fstart = fall_q.size();
        ustart = und_q.size();
        build_expected();
        feed(mark_last, tag);
        g = 0;
        while (fall_q.size() == fstart && g < 20000) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_busy_fall"}, fall_q.size() - fstart, 1);
        n = cap_q.size() - start;
        check({tag, "_pulses"}, n, exp_q.size());
        for (int j = 0; j < exp_q.size() && j < n; j++)
            check($sformatf("%s_bit%0d", tag, j), int'(cap_q[start + j]), int'(exp_q[j]));
        if (n > 0 && rise_q.size() > rstart && fall_q.size() > fstart) begin
            check({tag, "_first_bit_delay"}, nb_cyc_q[start] - rise_q[rstart], CPB - 1);
            check({tag, "_busy_tail"}, fall_q[fstart] - nb_cyc_q[cap_q.size() - 1], 1);
        end
        check({tag, "_underruns"}, und_q.size() - ustart, mark_last ? 0 : 1);
        if (!mark_last && und_q.size() > ustart)
            check({tag, "_underrun_at"}, und_q[ustart] - start, exp_q.size() - 2);
        check({tag, "_idle_lines"}, int'({tx_ready, data_out, eop}), 6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int start, g, base;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", int'(data_out), 1);
        check("rst_eop", int'(eop), 0);
        check("rst_new_bit", int'(new_bit), 0);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_underrun", int'(underrun), 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        pkt.delete(); pkt.push_back(8'h00);
        run_packet(1'b1, "b00");

        pkt.delete(); pkt.push_back(8'hFF);
        run_packet(1'b1, "bff");

        // Cross-byte stuffing; 9th data pulse of the first byte is the reload edge
        base = cap_q.size() + (SYNC_EN ? 8 : 0) + 8;
        pkt.delete(); pkt.push_back(8'h3F); pkt.push_back(8'h01);
        run_packet(1'b1, "cross");
        if (rdy_after_q.size() > base) begin
            check("cross_ready_at_reload", rdy_at_q[base], 0);
            check("cross_ready_after_reload", rdy_after_q[base], 1);
        end else begin
            check("cross_reload_seen", rdy_after_q.size(), base + 1);
        end

        pkt.delete(); pkt.push_back(8'hA5);
        run_packet(1'b0, "underrun");

        for (int p = 0; p < 6; p++) begin
            int nb;
            pkt.delete();
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++)
                pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            run_packet(1'b1, $sformatf("rnd%0d", p));
        end

        // Reset mid-packet
        start = cap_q.size();
        pkt.delete(); pkt.push_back(8'h55);
        feed(1'b1, "midrst");
        g = 0;
        while (cap_q.size() < start + 3 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("midrst_pulses_before", cap_q.size() - start, 3);
        @(negedge clk);
        check("midrst_pre_data_out", int'(data_out), 0);
        #2 n_rst = 1'b0;
        #1;
        check("midrst_data_out", int'(data_out), 1);
        check("midrst_tx_ready", int'(tx_ready), 1);
        check("midrst_tx_busy", int'(tx_busy), 0);
        check("midrst_eop", int'(eop), 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_quiet", cap_q.size() - start, 3);
        check("midrst_idle_busy", int'(tx_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
